// File: rtl/pdm_modulator_if.sv
// PCM sample handshake between an audio source and the PDM modulator.
// The source drives data_i/valid_i; the modulator answers with ready_o.
interface pdm_modulator_if;
    logic signed [15:0] data_i;
    logic               valid_i;
    logic               ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PDM modulator for a mono class-D amplifier.
// Takes one signed 16-bit PCM sample per OSR bits and emits a 1-bit stream.
module pdm_modulator #(
    parameter int CLK_DIV = 32,
    parameter int OSR     = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    pdm_modulator_if.slave pcm,
    output logic           pdm_clk_o,
    output logic           pdm_data_o,
    output logic           aud_sd_o,
    output logic           underrun_o,
    output logic           clip_o
);
    localparam int DATA_W = 16;
    localparam int ACC1_W = 20;
    localparam int ACC2_W = 24;
    localparam int SUM_W  = ACC2_W + 2;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int OSR_W  = $clog2(OSR);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

    localparam logic signed [DATA_W-1:0] PCM_MAX  = 16'sd24575;
    localparam logic signed [DATA_W-1:0] PCM_MIN  = -16'sd24576;
    localparam logic signed [ACC1_W-1:0] FB1_POS  = 20'sd32768;
    localparam logic signed [ACC1_W-1:0] FB1_NEG  = -20'sd32768;
    localparam logic signed [SUM_W-1:0]  FB2_POS  = 26'sd32768;
    localparam logic signed [SUM_W-1:0]  FB2_NEG  = -26'sd32768;
    localparam logic signed [SUM_W-1:0]  ACC2_MAX = 26'sd8388607;
    localparam logic signed [SUM_W-1:0]  ACC2_MIN = -26'sd8388608;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Keeps the modulator input at 0.75 full scale so the loop stays stable.
    function automatic logic signed [DATA_W-1:0] clamp_pcm(input logic signed [DATA_W-1:0] x);
        if (x > PCM_MAX) begin
            return PCM_MAX;
        end else if (x < PCM_MIN) begin
            return PCM_MIN;
        end
        return x;
    endfunction

    function automatic logic pcm_clipped(input logic signed [DATA_W-1:0] x);
        return (x > PCM_MAX) || (x < PCM_MIN);
    endfunction

    function automatic logic signed [ACC2_W-1:0] sat_acc2(input logic signed [SUM_W-1:0] x);
        if (x > ACC2_MAX) begin
            return ACC2_W'(ACC2_MAX);
        end else if (x < ACC2_MIN) begin
            return ACC2_W'(ACC2_MIN);
        end
        return x[ACC2_W-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       pclk_q, pclk_d;
    logic                       hold_full_q, hold_full_d;
    logic signed [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic signed [DATA_W-1:0]   cur_q, cur_d;
    logic [OSR_W-1:0]           osr_q, osr_d;
    logic signed [ACC1_W-1:0]   acc1_q, acc1_d;
    logic signed [ACC2_W-1:0]   acc2_q, acc2_d;
    logic                       out_q, out_d;
    logic                       underrun_q, underrun_d;
    logic                       clip_q, clip_d;

    logic                       tick;
    logic                       capture;
    logic                       consume;
    logic signed [ACC1_W-1:0]   fb1;
    logic signed [SUM_W-1:0]    fb2;
    logic signed [ACC1_W-1:0]   x_ext;
    logic signed [ACC1_W-1:0]   acc1_nxt;
    logic signed [SUM_W-1:0]    acc2_sum;
    logic signed [ACC2_W-1:0]   acc2_nxt;

    always_comb begin
        state_d     = state_q;
        osr_d       = osr_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        out_d       = out_q;
        cur_d       = cur_q;
        underrun_d  = underrun_q;
        consume     = 1'b0;

        tick        = (div_q == DIV_LAST);
        div_d       = tick ? '0 : div_q + 1'b1;
        // Registered from the next count so the clock rises with each new bit.
        pclk_d      = (div_d < DIV_HALF);

        capture     = pcm.valid_i & ~hold_full_q;
        clip_d      = capture & pcm_clipped(pcm.data_i);
        hold_data_d = capture ? clamp_pcm(pcm.data_i) : hold_data_q;

        fb1      = out_q ? FB1_POS : FB1_NEG;
        fb2      = out_q ? FB2_POS : FB2_NEG;
        x_ext    = {{(ACC1_W - DATA_W){cur_q[DATA_W-1]}}, cur_q};
        acc1_nxt = acc1_q + x_ext - fb1;
        acc2_sum = {{(SUM_W - ACC2_W){acc2_q[ACC2_W-1]}}, acc2_q}
                 + {{(SUM_W - ACC1_W){acc1_nxt[ACC1_W-1]}}, acc1_nxt}
                 - fb2;
        acc2_nxt = sat_acc2(acc2_sum);

        case (state_q)
            IDLE: begin
                osr_d      = '0;
                acc1_d     = '0;
                acc2_d     = '0;
                out_d      = 1'b0;
                underrun_d = 1'b0;
                if (tick && en_i && hold_full_q) begin
                    state_d = RUN;
                    cur_d   = hold_data_q;
                    consume = 1'b1;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d    = IDLE;
                    osr_d      = '0;
                    acc1_d     = '0;
                    acc2_d     = '0;
                    out_d      = 1'b0;
                    underrun_d = 1'b0;
                end else if (tick) begin
                    acc1_d = acc1_nxt;
                    acc2_d = acc2_nxt;
                    out_d  = ~acc2_nxt[ACC2_W-1];
                    osr_d  = (osr_q == OSR_LAST) ? '0 : osr_q + 1'b1;
                    // Sample boundary: the current sample is repeated on a miss.
                    if (osr_q == OSR_LAST) begin
                        if (hold_full_q) begin
                            cur_d   = hold_data_q;
                            consume = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        hold_full_d = capture | (hold_full_q & ~consume);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            pclk_q      <= 1'b0;
            hold_full_q <= 1'b0;
            osr_q       <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            out_q       <= 1'b0;
            underrun_q  <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pclk_q      <= pclk_d;
            hold_full_q <= hold_full_d;
            osr_q       <= osr_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            out_q       <= out_d;
            underrun_q  <= underrun_d;
            clip_q      <= clip_d;
        end
    end

    // Sample registers carry no reset; hold_full and the FSM qualify them.
    always_ff @(posedge clk_i) begin
        hold_data_q <= hold_data_d;
        cur_q       <= cur_d;
    end

    assign pcm.ready_o = ~hold_full_q;
    assign pdm_clk_o   = pclk_q;
    assign pdm_data_o  = out_q;
    assign aud_sd_o    = (state_q == RUN);
    assign underrun_o  = underrun_q;
    assign clip_o      = clip_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: directed scenarios with random PCM data, checked
// bit-for-bit against an integer model of the second-order loop.
module tb_pdm_modulator;
    localparam int CLK_DIV = 32;
    localparam int OSR     = 64;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic pdm_clk, pdm_data, aud_sd, underrun, clip;

    pdm_modulator_if pcm ();

    pdm_modulator #(.CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .pcm        (pcm),
        .pdm_clk_o  (pdm_clk),
        .pdm_data_o (pdm_data),
        .aud_sd_o   (aud_sd),
        .underrun_o (underrun),
        .clip_o     (clip)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Feed modes: 0 none, 1 constant, 2 fresh random after each accept, 3 one-shot.
    int                 feed_mode   = 0;
    logic signed [15:0] cdata       = '0;
    logic signed [15:0] rdata       = '0;
    int                 oneshot_left = 0;

    int     msamp[$];
    int     obs_bits[$];
    longint acc_cyc[$];
    longint cycle     = 0;
    int     run_k     = -1;
    logic   pclk_prev = 1'b0;

    int m_acc1 = 0;
    int m_acc2 = 0;
    int m_out  = 0;

    function automatic int clamp_model(int v);
        if (v > 24575) return 24575;
        if (v < -24576) return -24576;
        return v;
    endfunction

    function automatic int is_clipped(int v);
        return ((v > 24575) || (v < -24576)) ? 1 : 0;
    endfunction

    function automatic int wrap20(int v);
        int u;
        u = v & 32'h000F_FFFF;
        if (u >= 524288) u = u - 1048576;
        return u;
    endfunction

    function automatic int sat24(int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    function automatic int samp_at(int j);
        if (msamp.size() == 0) return 0;
        if (j < msamp.size()) return msamp[j];
        return msamp[msamp.size()-1];
    endfunction

    task automatic model_step(input int x);
        int fb;
        fb = (m_out != 0) ? 32768 : -32768;
        m_acc1 = wrap20(m_acc1 + x - fb);
        m_acc2 = sat24(m_acc2 + m_acc1 - fb);
        m_out  = (m_acc2 >= 0) ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cyc();
        logic acc_now;
        int   raw;
        case (feed_mode)
            1:       begin pcm.valid_i = 1'b1; pcm.data_i = cdata; end
            2:       begin pcm.valid_i = 1'b1; pcm.data_i = rdata; end
            3:       begin pcm.valid_i = (oneshot_left > 0); pcm.data_i = cdata; end
            default: begin pcm.valid_i = 1'b0; pcm.data_i = '0; end
        endcase
        raw     = int'(pcm.data_i);
        acc_now = pcm.valid_i && pcm.ready_o && !rst;
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            msamp.delete();
            obs_bits.delete();
            acc_cyc.delete();
        end
        if (acc_now) begin
            msamp.push_back(clamp_model(raw));
            acc_cyc.push_back(cycle);
            if (feed_mode == 2) rdata = 16'($urandom);
            if (feed_mode == 3) oneshot_left--;
        end
        check("clip_pulse", clip, (acc_now && is_clipped(raw) != 0) ? 1 : 0);
        if (!aud_sd) begin
            run_k = -1;
        end else if (pdm_clk && !pclk_prev) begin
            run_k++;
            if (run_k == 0) begin
                m_acc1 = 0;
                m_acc2 = 0;
                m_out  = 0;
                obs_bits.delete();
            end else begin
                model_step(samp_at((run_k - 1) / OSR));
            end
            obs_bits.push_back(int'(pdm_data));
            check("pdm_bit", pdm_data, m_out);
        end
        pclk_prev = pdm_clk;
    endtask

    task automatic run_bits(input int n);
        int budget;
        budget = n * CLK_DIV + 4 * CLK_DIV;
        while (obs_bits.size() < n && budget > 0) begin
            cyc();
            budget--;
        end
        check("bits_reached", (obs_bits.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        feed_mode = 0;
        cyc();
        rst       = 1'b0;
    endtask

    function automatic int ones(input int start, input int len);
        int s;
        s = 0;
        for (int i = start; i < start + len; i++) begin
            if (i < obs_bits.size()) s += obs_bits[i];
        end
        return s;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},    pcm.ready_o, 1);
        check({pfx, "_aud_sd"},   aud_sd, 0);
        check({pfx, "_pdm_data"}, pdm_data, 0);
        check({pfx, "_pdm_clk"},  pdm_clk, 0);
        check({pfx, "_underrun"}, underrun, 0);
        check({pfx, "_clip"},     clip, 0);
    endtask

    initial begin
        logic hist[80];
        int   r0, r1, highs;

        rst = 1'b1;
        en  = 1'b0;
        pcm.valid_i = 1'b0;
        pcm.data_i  = '0;
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Free-running bit clock: 32-cycle period, 16 cycles high.
        for (int i = 0; i < 40; i++) cyc();
        for (int i = 0; i < 80; i++) begin
            cyc();
            hist[i] = pdm_clk;
        end
        r0 = -1;
        r1 = -1;
        for (int i = 1; i < 80; i++) begin
            if (hist[i] && !hist[i-1]) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
        end
        highs = 0;
        if (r0 >= 0 && r1 > r0) begin
            for (int i = r0; i < r1; i++) highs += int'(hist[i]);
        end
        check("pdm_clk_period", r1 - r0, CLK_DIV);
        check("pdm_clk_high", highs, CLK_DIV / 2);

        // Silence, valid held high: 50 % density and one accept per sample.
        do_reset();
        en = 1'b1;
        feed_mode = 1;
        cdata = 16'sd0;
        run_bits(1);
        check("aud_sd_on", aud_sd, 1);
        run_bits(145);
        check_rng("zero_win0", ones(17, 64), 31, 33);
        check_rng("zero_win1", ones(81, 64), 31, 33);
        for (int i = 2; i < acc_cyc.size(); i++) begin
            check("accept_interval", int'(acc_cyc[i] - acc_cyc[i-1]), OSR * CLK_DIV);
        end
        check_rng("accept_count", acc_cyc.size(), 4, 4);

        // Positive overrange clamps to +0.75 FS.
        do_reset();
        en = 1'b1;
        feed_mode = 1;
        cdata = 16'sh7FFF;
        run_bits(145);
        check_rng("pos_win0", ones(17, 64), 54, 58);
        check_rng("pos_win1", ones(81, 64), 54, 58);

        // Negative overrange clamps to -0.75 FS.
        do_reset();
        en = 1'b1;
        feed_mode = 1;
        cdata = 16'sh8000;
        run_bits(145);
        check_rng("neg_win0", ones(17, 64), 6, 10);
        check_rng("neg_win1", ones(81, 64), 6, 10);

        // Random sample stream, then reset in the middle of a sample.
        do_reset();
        en = 1'b1;
        rdata = 16'($urandom);
        feed_mode = 2;
        run_bits(4 * OSR + 2);
        for (int i = 0; i < 7; i++) cyc();
        rst = 1'b1;
        cyc();
        check_reset_outputs("midrun_rst");
        rst = 1'b0;
        feed_mode = 0;
        en = 1'b0;
        cyc();

        // Single sample then starve the input.
        do_reset();
        en = 1'b1;
        cdata = 16'($urandom_range(0, 49151) - 24576);
        oneshot_left = 1;
        feed_mode = 3;
        run_bits(64);
        check("underrun_before", underrun, 0);
        run_bits(65);
        check("underrun_set", underrun, 1);
        run_bits(2 * OSR + 2);
        check("underrun_sticky", underrun, 1);
        en = 1'b0;
        cyc();
        check("underrun_clear", underrun, 0);
        check("idle_aud_sd", aud_sd, 0);
        check("idle_pdm_data", pdm_data, 0);
        check("idle_ready", pcm.ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
